// File: rtl/cdc_multibit_tx_sched_pkg.sv
// Shared types and constants for the multibit CDC transmit scheduler.
package cdc_multibit_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } sched_state_t;

  localparam int unsigned GAP_CNT_W = 8;

  // Index width that stays at least one bit wide for tiny requester counts.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdc_multibit_tx_pick.sv
// Combinational winner selection for the CDC transmit scheduler.
// CDC_MULTIBIT_TX_SCHED_FIXED_PRIO_EN selects lowest-index priority instead of round-robin.
module cdc_multibit_tx_pick
  import cdc_multibit_tx_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  assign any_valid = |req_valid;

`ifdef CDC_MULTIBIT_TX_SCHED_FIXED_PRIO_EN

  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan downward so the lowest asserted index is the last one written.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end

`else

  logic            found;
  logic [ID_W-1:0] idx;

  // Search starts at the pointer and wraps modulo NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + 32'(k)) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

`endif

endmodule

// File: rtl/cdc_multibit_tx_sched.sv
// Source-domain scheduler sharing one valid-pulse multibit CDC channel among requesters.
// CDC_MULTIBIT_TX_SCHED_FIXED_PRIO_EN switches arbitration to fixed lowest-index priority.
module cdc_multibit_tx_sched
  import cdc_multibit_tx_sched_pkg::*;
#(
  parameter int unsigned           NUM_REQ        = 4,
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           MIN_GAP_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_DATA      = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          cdc_valid,
  output logic [DATA_WIDTH-1:0]         cdc_data,
  output logic                          busy,
  output logic [id_width(NUM_REQ)-1:0]  grant_id
);

  localparam int unsigned          IdW     = id_width(NUM_REQ);
  localparam logic [IdW-1:0]       LastIdx = IdW'(NUM_REQ - 1);
  localparam logic [GAP_CNT_W-1:0] GapLoad = GAP_CNT_W'(MIN_GAP_CYCLES);

  sched_state_t          state_q;
  logic [IdW-1:0]        rr_ptr_q;
  logic [GAP_CNT_W-1:0]  gap_cnt_q;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [IdW-1:0]        pick_idx;
  logic                  pick_any;
  logic [DATA_WIDTH-1:0] pick_data;
  logic                  accept;

  cdc_multibit_tx_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (IdW)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  // Grant is one-hot, so at most one lane contributes.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept    = (state_q == IDLE) && pick_any;
  assign req_ready = accept ? pick_grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cdc_valid <= 1'b0;
      cdc_data  <= IDLE_DATA;
      busy      <= 1'b0;
      grant_id  <= '0;
      rr_ptr_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cdc_valid <= 1'b1;
            cdc_data  <= pick_data;
            grant_id  <= pick_idx;
            busy      <= 1'b1;
            rr_ptr_q  <= (pick_idx == LastIdx) ? '0 : pick_idx + IdW'(1);
            state_q   <= PULSE;
          end
        end
        PULSE: begin
          cdc_valid <= 1'b0;
          gap_cnt_q <= GapLoad;
          state_q   <= GAP;
        end
        GAP: begin
          // Payload stays stable until the last gap cycle so the receiver samples it safely.
          if (gap_cnt_q <= GAP_CNT_W'(1)) begin
            gap_cnt_q <= '0;
            busy      <= 1'b0;
            cdc_data  <= IDLE_DATA;
            state_q   <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_CNT_W'(1);
          end
        end
        default: begin
          cdc_valid <= 1'b0;
          busy      <= 1'b0;
          cdc_data  <= IDLE_DATA;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule
